// File: rtl/coriolis_join_mul_pipe_pkg.sv
// Shared widths and helpers for the join/multiply pipeline and its output FIFO.
package coriolis_join_mul_pipe_pkg;

    localparam int STREAMW_DEF = 34;
    localparam int FRAC_DEF    = 16;

    // The result keeps product bits [FRAC+STREAMW-1 : FRAC].
    localparam int RES_LSB_DEF = FRAC_DEF;
    localparam int RES_MSB_DEF = FRAC_DEF + STREAMW_DEF - 1;

    // One extra bit so the counter can hold the value DEPTH itself.
    function automatic int credit_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int prod_width(input int streamw);
        return 2 * streamw;
    endfunction

endpackage

// File: rtl/coriolis_stream_fifo.sv
// First-word fall-through FIFO: the head entry is presented on rd_data whenever !empty.
module coriolis_stream_fifo
    import coriolis_join_mul_pipe_pkg::*;
#(
    parameter int STREAMW = STREAMW_DEF,
    parameter int DEPTH   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [STREAMW-1:0] wr_data,
    input  logic               rd_en,
    output logic [STREAMW-1:0] rd_data,
    output logic               empty,
    output logic               full
);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = AW + 1;

    logic [STREAMW-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CNTW-1:0]    count;
    logic               wr_ok;
    logic               rd_ok;

    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign empty   = (count == '0);
    assign full    = (count == CNTW'(DEPTH));
    assign rd_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; empty hides stale entries and the array can map to RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/coriolis_join_mul_pipe.sv
// Joins two operand streams, multiplies them in a LAT-stage fixed-point pipeline and
// buffers results in a FIFO; credits guarantee the never-stalling pipeline cannot overflow it.
module coriolis_join_mul_pipe
    import coriolis_join_mul_pipe_pkg::*;
#(
    parameter int STREAMW = STREAMW_DEF,
    parameter int FRAC    = FRAC_DEF,
    parameter int LAT     = 4,
    parameter int DEPTH   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ivalid_in1_s0,
    input  logic [STREAMW-1:0] in1_s0,
    input  logic               ivalid_in2_s0,
    input  logic [STREAMW-1:0] in2_s0,
    output logic               iready,
    output logic               ovalid_out1_s0,
    input  logic               oready_out1_s0,
    output logic [STREAMW-1:0] out1_s0
);
    localparam int CW = credit_width(DEPTH);
    localparam int PW = prod_width(STREAMW);

    logic [CW-1:0]         credits;
    logic                  fire;
    logic                  pop;
    logic                  empty;
    logic                  full;
    logic [STREAMW-1:0]    head;
    logic signed [PW-1:0]  op_a;
    logic signed [PW-1:0]  op_b;
    logic [LAT-1:0]        valid_pipe;
    logic [STREAMW-1:0]    data_pipe [LAT];

    // Credits count every beat in the pipeline or the FIFO, so ready never looks at ivalid/oready.
    assign iready         = (credits < CW'(DEPTH)) && !rst;
    assign fire           = ivalid_in1_s0 && ivalid_in2_s0 && iready;
    assign ovalid_out1_s0 = !empty && !rst;
    assign pop            = ovalid_out1_s0 && oready_out1_s0;
    assign out1_s0        = ovalid_out1_s0 ? head : '0;

    assign op_a = PW'($signed(in1_s0));
    assign op_b = PW'($signed(in2_s0));

    always_ff @(posedge clk) begin
        if (rst) begin
            credits <= '0;
        end else begin
            case ({fire, pop})
                2'b10:   credits <= credits + CW'(1);
                2'b01:   credits <= credits - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_pipe <= '0;
        end else begin
            valid_pipe[0] <= fire;
            for (int i = 1; i < LAT; i++) valid_pipe[i] <= valid_pipe[i-1];
        end
    end

    // Arithmetic shift floors toward -inf; the cast keeps the low STREAMW bits (wrap, no saturation).
    always_ff @(posedge clk) begin
        if (fire) data_pipe[0] <= STREAMW'((op_a * op_b) >>> FRAC);
        for (int i = 1; i < LAT; i++) data_pipe[i] <= data_pipe[i-1];
    end

    coriolis_stream_fifo #(
        .STREAMW (STREAMW),
        .DEPTH   (DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (valid_pipe[LAT-1] && !full),
        .wr_data (data_pipe[LAT-1]),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (empty),
        .full    (full)
    );

endmodule

// File: tb/tb_coriolis_join_mul_pipe.sv
// Randomized and directed bench for coriolis_join_mul_pipe against an in-order latency model.
module tb_coriolis_join_mul_pipe;

    localparam int W     = 34;
    localparam int FRAC  = 16;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;

    typedef struct {
        logic [W-1:0] val;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         iv1, iv2, iready, ovalid, oready;
    logic [W-1:0] in1, in2, out1;

    exp_t q[$];
    int   cyc = 0;
    int   accepts = 0;
    int   pops = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    coriolis_join_mul_pipe #(
        .STREAMW (W),
        .FRAC    (FRAC),
        .LAT     (LAT),
        .DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ivalid_in1_s0  (iv1),
        .in1_s0         (in1),
        .ivalid_in2_s0  (iv2),
        .in2_s0         (in2),
        .iready         (iready),
        .ovalid_out1_s0 (ovalid),
        .oready_out1_s0 (oready),
        .out1_s0        (out1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // floor(a*b / 2^FRAC) reduced modulo 2^W, with a and b as signed integers.
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sa, sb, p, q_floor;
        sa = $signed({{W{a[W-1]}}, a});
        sb = $signed({{W{b[W-1]}}, b});
        p  = sa * sb;
        q_floor = p >>> FRAC;
        return q_floor[W-1:0];
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        if (r[63]) return {{14{r[19]}}, r[19:0]};
        return r[W-1:0];
    endfunction

    // Reference: a beat accepted before edge k+1 is visible from cycle k+1+LAT, strictly in order.
    always @(negedge clk) begin
        exp_t e;
        logic exp_valid;
        if (cyc > 0) begin
            if (rst) begin
                check("rst_iready", iready, 0);
                check("rst_ovalid", ovalid, 0);
                q.delete();
            end else begin
                check("iready", iready, (q.size() < DEPTH));
                check("credits", dut.credits, q.size());
                exp_valid = (q.size() > 0) && (q[0].due <= cyc);
                check("ovalid", ovalid, exp_valid);
                if (exp_valid) check("out1", out1, q[0].val);
                if (ovalid && oready && q.size() > 0) begin
                    void'(q.pop_front());
                    pops++;
                end
                if (iv1 && iv2 && iready) begin
                    e.val = model(in1, in2);
                    e.due = cyc + 1 + LAT;
                    q.push_back(e);
                    accepts++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int guard;
        iv1 = 1'b0;
        iv2 = 1'b0;
        oready = 1'b1;
        guard = 0;
        while ((q.size() != 0 || ovalid) && guard < 100) begin
            tick();
            guard++;
        end
        check({tag, "_drain_timeout"}, (guard < 100), 1);
    endtask

    // One isolated beat: checks exact latency, value and that only one output appears.
    task automatic beat(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp);
        drain(tag);
        in1 = a;
        in2 = b;
        iv1 = 1'b1;
        iv2 = 1'b1;
        tick();
        iv1 = 1'b0;
        iv2 = 1'b0;
        repeat (LAT - 1) tick();
        check({tag, "_early"}, ovalid, 0);
        tick();
        check({tag, "_valid"}, ovalid, 1);
        check({tag, "_data"}, out1, exp);
        tick();
        check({tag, "_once"}, ovalid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, p0;
        rst = 1'b1;
        iv1 = 1'b0;
        iv2 = 1'b0;
        in1 = '0;
        in2 = '0;
        oready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("reset_iready", iready, 1);
        check("reset_ovalid", ovalid, 0);
        check("reset_out1", out1, 0);

        beat("single", 34'h0_0002_0000, 34'h0_0001_8000, 34'h0_0003_0000);
        beat("neg_one", 34'h3_FFFF_0000, 34'h0_0000_0001, 34'h3_FFFF_FFFF);
        beat("floor_neg", 34'h3_FFFF_FFFF, 34'h0_0000_0001, 34'h3_FFFF_FFFF);
        beat("floor_pos", 34'h0_0000_0001, 34'h0_0000_0001, 34'h0_0000_0000);

        // Only one side valid: nothing consumed until both are.
        drain("partial");
        a0 = accepts;
        p0 = pops;
        iv1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in1 = rnd();
            in2 = rnd();
            tick();
        end
        check("partial_none", accepts - a0, 0);
        iv2 = 1'b1;
        in1 = 34'h0_0004_0000;
        in2 = 34'h3_FFFE_0000;
        tick();
        iv1 = 1'b0;
        iv2 = 1'b0;
        drain("partial");
        check("partial_accepts", accepts - a0, 1);
        check("partial_pops", pops - p0, 1);

        // Backpressure: the credit limit stops acceptance after DEPTH beats.
        drain("bp");
        oready = 1'b0;
        a0 = accepts;
        p0 = pops;
        iv1 = 1'b1;
        iv2 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in1 = rnd();
            in2 = rnd();
            tick();
        end
        check("bp_accepts", accepts - a0, DEPTH);
        check("bp_iready_low", iready, 0);
        iv1 = 1'b0;
        iv2 = 1'b0;
        repeat (LAT + 2) tick();
        drain("bp");
        check("bp_pops", pops - p0, DEPTH);

        // Sustained throughput with oready held high.
        a0 = accepts;
        p0 = pops;
        iv1 = 1'b1;
        iv2 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in1 = rnd();
            in2 = rnd();
            tick();
        end
        check("tput_accepts", accepts - a0, 100);
        drain("tput");
        check("tput_pops", pops - p0, 100);

        // Random valids and backpressure.
        for (int i = 0; i < 400; i++) begin
            iv1 = ($urandom_range(3) != 0);
            iv2 = ($urandom_range(3) != 0);
            oready = $urandom_range(1);
            in1 = rnd();
            in2 = rnd();
            tick();
        end
        drain("rand");

        // Reset with beats in both the pipeline and the FIFO.
        oready = 1'b0;
        a0 = accepts;
        iv1 = 1'b1;
        iv2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in1 = rnd();
            in2 = rnd();
            tick();
        end
        iv1 = 1'b0;
        iv2 = 1'b0;
        tick();
        check("mid_accepts", accepts - a0, 5);
        check("mid_ovalid_before", ovalid, 1);
        oready = 1'b1;
        rst = 1'b1;
        #1;
        check("mid_rst_iready", iready, 0);
        check("mid_rst_ovalid", ovalid, 0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_ovalid", ovalid, 0);
        check("post_rst_credits", dut.credits, 0);
        check("post_rst_iready", iready, 1);
        p0 = pops;
        repeat (LAT + 3) tick();
        check("post_rst_no_stale", pops - p0, 0);
        beat("post_rst", 34'h0_0000_8000, 34'h0_0000_8000, 34'h0_0000_4000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
